// File: rtl/impulse_readout_pkg.sv
// Shared state encoding, synchronizer depth and frame-length helper for the impulse readout sequencer.
// Build option READOUT_PARITY_EN appends an even-parity bit to every channel word.
package impulse_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNAP  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int SYNC_STAGES = 2;

`ifdef READOUT_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // SNAP + DONE plus one LOAD and the serial bits for every channel.
  function automatic int frame_len(input int num_ch, input int cnt_w);
    return 2 + num_ch * (1 + cnt_w + PARITY_BITS);
  endfunction

endpackage

// File: rtl/rtc_sync_edge.sv
// Brings the asynchronous RTC tick into clk and emits a one-cycle pulse per rising edge.
module rtc_sync_edge
  import impulse_readout_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse_out
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], async_in};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign pulse_out = sync_reg[STAGES-1] & ~prev_reg;

endmodule

// File: rtl/impulse_readout_seq.sv
// Readout sequencer: on each RTC tick snapshots the counter bank and streams every channel out MSB first.
// Build option READOUT_PARITY_EN adds an even-parity bit after each channel word.
module impulse_readout_seq
  import impulse_readout_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rtc_in,
  input  logic [CNT_W-1:0]  cnt_data_in,
  input  logic              overrun_clr_in,
  output logic              snap_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              sl_out,
  output logic              serial_out,
  output logic              frame_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              overrun_out
);

  localparam int SHIFT_LEN = CNT_W + PARITY_BITS;
  localparam int BIT_W     = $clog2(CNT_W + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(SHIFT_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(NUM_CH - 1);

  state_t              state_reg;
  logic [CNT_W-1:0]    shift_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                snap_reg;
  logic                serial_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                overrun_reg;
  logic                tick_p;
`ifdef READOUT_PARITY_EN
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(CNT_W - 1);
  logic                parity_reg;
`endif

  rtc_sync_edge #(.STAGES(SYNC_STAGES)) u_rtc_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (rtc_in),
    .pulse_out (tick_p)
  );

  // shift_reg holds the bits still to come; serial_reg is the bit on the pin this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      addr_reg    <= '0;
      snap_reg    <= 1'b0;
      serial_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
`ifdef READOUT_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      snap_reg   <= 1'b0;
      done_reg   <= 1'b0;
      serial_reg <= 1'b0;

      if (tick_p && state_reg != ST_IDLE)
        overrun_reg <= 1'b1;
      else if (overrun_clr_in)
        overrun_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (tick_p) begin
            state_reg <= ST_SNAP;
            snap_reg  <= 1'b1;
            busy_reg  <= 1'b1;
            addr_reg  <= '0;
          end
        end
        ST_SNAP: state_reg <= ST_LOAD;
        ST_LOAD: begin
          serial_reg  <= cnt_data_in[CNT_W-1];
          shift_reg   <= {cnt_data_in[CNT_W-2:0], 1'b0};
          bit_cnt_reg <= '0;
          state_reg   <= ST_SHIFT;
`ifdef READOUT_PARITY_EN
          parity_reg  <= ^cnt_data_in;
`endif
        end
        ST_SHIFT: begin
          shift_reg   <= {shift_reg[CNT_W-2:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_reg <= '0;
            if (addr_reg == LAST_CH) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              addr_reg  <= '0;
            end else begin
              addr_reg  <= addr_reg + 1'b1;
              state_reg <= ST_LOAD;
            end
          end else begin
`ifdef READOUT_PARITY_EN
            if (bit_cnt_reg == LAST_DATA)
              serial_reg <= parity_reg;
            else
              serial_reg <= shift_reg[CNT_W-1];
`else
            serial_reg <= shift_reg[CNT_W-1];
`endif
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign snap_out    = snap_reg;
  assign addr_out    = addr_reg;
  assign sl_out      = (state_reg == ST_LOAD);
  assign frame_out   = (state_reg == ST_SHIFT);
  assign serial_out  = serial_reg;
  assign busy_out    = busy_reg;
  assign done_out    = done_reg;
  assign overrun_out = overrun_reg;

endmodule

// File: tb/tb_impulse_readout_seq.sv
// Self-checking bench for impulse_readout_seq: vector table, random frames and multi-cycle corner sequences.
module tb_impulse_readout_seq;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 4;
`ifdef READOUT_PARITY_EN
  localparam int BITS_PER_CH = CNT_W + 1;
`else
  localparam int BITS_PER_CH = CNT_W;
`endif
  localparam int FLEN = 2 + NUM_CH * (1 + BITS_PER_CH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rtc_in = 1'b0;
  logic [CNT_W-1:0]  cnt_data_in;
  logic              overrun_clr_in = 1'b0;
  logic              snap_out;
  logic [ADDR_W-1:0] addr_out;
  logic              sl_out;
  logic              serial_out;
  logic              frame_out;
  logic              busy_out;
  logic              done_out;
  logic              overrun_out;

  logic [CNT_W-1:0]  chan_word [NUM_CH];

  impulse_readout_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rtc_in         (rtc_in),
    .cnt_data_in    (cnt_data_in),
    .overrun_clr_in (overrun_clr_in),
    .snap_out       (snap_out),
    .addr_out       (addr_out),
    .sl_out         (sl_out),
    .serial_out     (serial_out),
    .frame_out      (frame_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .overrun_out    (overrun_out)
  );

  always #5 clk = ~clk;

  // External counter-bank mux.
  assign cnt_data_in = (int'(addr_out) < NUM_CH) ? chan_word[addr_out[2:0]] : '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-frame observations, sampled on the falling edge.
  int snap_n, done_n, sl_n, frame_n, busy_n, addr_max, idle_serial_n;
  int snap_first, snap_last, done_first, done_last, rise_cyc;
  bit bits_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (snap_out) begin
        snap_n++;
        if (snap_first < 0) snap_first = cyc;
        snap_last = cyc;
      end
      if (done_out) begin
        done_n++;
        if (done_first < 0) done_first = cyc;
        done_last = cyc;
      end
      if (sl_out) sl_n++;
      if (frame_out) begin
        frame_n++;
        bits_q.push_back(serial_out);
      end else if (serial_out) begin
        idle_serial_n++;
      end
      if (busy_out) busy_n++;
      if (int'(addr_out) > addr_max) addr_max = int'(addr_out);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    snap_n = 0; done_n = 0; sl_n = 0; frame_n = 0; busy_n = 0;
    addr_max = 0; idle_serial_n = 0;
    snap_first = -1; snap_last = -1; done_first = -1; done_last = -1;
    bits_q.delete();
  endtask

  task automatic set_words(input logic [63:0] words);
    for (int ch = 0; ch < NUM_CH; ch++) chan_word[ch] = words[63-8*ch -: 8];
  endtask

  task automatic tick_edge();
    @(posedge clk); #1;
  endtask

  task automatic pulse_rtc();
    tick_edge();
    rtc_in = 1'b1;
    rise_cyc = cyc;
    tick_edge();
    tick_edge();
    rtc_in = 1'b0;
  endtask

  task automatic wait_done_count(input int n_req, input int bound);
    int n = 0;
    while (done_n < n_req && n < bound) begin tick_edge(); n++; end
  endtask

  task automatic wait_sl(input int n_req);
    int n = 0;
    while (sl_n < n_req && n < FLEN) begin @(posedge clk); n++; end
  endtask

  // Reference: every channel word MSB first, optionally followed by its even parity.
  task automatic check_stream(input string name, input logic [63:0] words);
    bit exp_q[$];
    int mism = 0;
    logic [7:0] w;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w = words[63-8*ch -: 8];
      for (int b = CNT_W - 1; b >= 0; b--) exp_q.push_back(w[b]);
`ifdef READOUT_PARITY_EN
      exp_q.push_back(^w);
`endif
    end
    check({name, "_len"}, 64'(bits_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < bits_q.size(); i++)
      if (bits_q[i] != exp_q[i]) mism++;
    check({name, "_stream"}, 64'(mism), 64'd0);
  endtask

  task automatic check_frame(input string name, input logic [63:0] words);
    check({name, "_snap_lat"}, 64'(snap_first - rise_cyc), 64'd3);
    check({name, "_snap_n"}, 64'(snap_n), 64'd1);
    check({name, "_done_n"}, 64'(done_n), 64'd1);
    check({name, "_done_gap"}, 64'(done_last - snap_first), 64'(FLEN - 1));
    check({name, "_frame_n"}, 64'(frame_n), 64'(NUM_CH * BITS_PER_CH));
    check({name, "_sl_n"}, 64'(sl_n), 64'(NUM_CH));
    check({name, "_busy_n"}, 64'(busy_n), 64'(FLEN));
    check({name, "_addr_max"}, 64'(addr_max), 64'(NUM_CH - 1));
    check({name, "_idle_serial"}, 64'(idle_serial_n), 64'd0);
    check_stream(name, words);
    $display("frame %s words=%016h snap@%0d done@%0d bits=%0d overrun=%0b",
             name, words, snap_first, done_last, bits_q.size(), overrun_out);
  endtask

  task automatic run_frame(input string name, input logic [63:0] words, input int gap);
    set_words(words);
    clear_stats();
    repeat (gap) tick_edge();
    pulse_rtc();
    wait_done_count(1, FLEN + 20);
    repeat (3) tick_edge();
    check_frame(name, words);
  endtask

  function automatic logic [7:0] grab8(input int start);
    logic [7:0] g = 'x;
    if (bits_q.size() >= start + 8)
      for (int i = 0; i < 8; i++) g[7-i] = bits_q[start+i];
    return g;
  endfunction

  typedef struct {
    string       name;
    logic [63:0] words;
    logic [7:0]  exp_ch0;
    logic [7:0]  exp_ch7;
    logic        exp_par0;
    int          gap;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pat_a;
    logic [63:0] rw;
    int s, bad, save_rise;

    vecs[0] = '{"pattern_a", 64'hA0A1A2A3A4A5A6A7, 8'hA0, 8'hA7, 1'b0, 2};
    vecs[1] = '{"all_07",    64'h0707070707070707, 8'h07, 8'h07, 1'b1, 0};
    vecs[2] = '{"all_03",    64'h0303030303030303, 8'h03, 8'h03, 1'b0, 5};
    vecs[3] = '{"walk",      64'h8040201008040201, 8'h80, 8'h01, 1'b1, 1};
    vecs[4] = '{"zeros",     64'h0000000000000000, 8'h00, 8'h00, 1'b0, 3};
    vecs[5] = '{"ones",      64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF, 1'b0, 0};
    pat_a = 64'hA0A1A2A3A4A5A6A7;
    set_words(pat_a);
    clear_stats();

    // Reset held with rtc_in toggling
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ({snap_out, addr_out, sl_out, serial_out, frame_out, busy_out, done_out, overrun_out} != '0) bad++;
      rtc_in = ~rtc_in;
    end
    check("rst_hold_outputs", 64'(bad), 64'd0);
    rtc_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ({snap_out, addr_out, sl_out, serial_out, frame_out, busy_out, done_out, overrun_out} != '0) bad++;
    end
    check("post_rst_idle", 64'(bad), 64'd0);
    check("post_rst_snaps", 64'(snap_n), 64'd0);
    $display("reset sequence done cyc=%0d", cyc);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].name, vecs[v].words, vecs[v].gap);
      check({vecs[v].name, "_ch0"}, 64'(grab8(0)), 64'(vecs[v].exp_ch0));
      check({vecs[v].name, "_ch7"}, 64'(grab8(7 * BITS_PER_CH)), 64'(vecs[v].exp_ch7));
`ifdef READOUT_PARITY_EN
      if (bits_q.size() > CNT_W)
        check({vecs[v].name, "_par0"}, 64'(bits_q[CNT_W]), 64'(vecs[v].exp_par0));
      else
        check({vecs[v].name, "_par0"}, 64'hDEAD, 64'(vecs[v].exp_par0));
`endif
    end
    check("overrun_idle_after_table", 64'(overrun_out), 64'd0);

    // Random frames
    for (int r = 0; r < 6; r++) begin
      rw = {$urandom, $urandom};
      run_frame($sformatf("rand%0d", r), rw, int'($urandom_range(0, 7)));
    end

    // Overrun: second tick during channel 4 shift
    set_words(pat_a);
    clear_stats();
    pulse_rtc();
    save_rise = rise_cyc;
    wait_sl(5);
    pulse_rtc();
    rise_cyc = save_rise;
    wait_done_count(1, FLEN + 20);
    repeat (12) tick_edge();
    check("ovr_flag", 64'(overrun_out), 64'd1);
    check_frame("ovr_frame", pat_a);
    overrun_clr_in = 1'b1;
    tick_edge();
    overrun_clr_in = 1'b0;
    @(negedge clk);
    check("ovr_clear", 64'(overrun_out), 64'd0);

    // Overrun set and clear in the same cycle
    clear_stats();
    pulse_rtc();
    wait_sl(2);
    tick_edge();
    rtc_in = 1'b1;
    tick_edge();
    tick_edge();
    rtc_in = 1'b0;
    overrun_clr_in = 1'b1;
    tick_edge();
    overrun_clr_in = 1'b0;
    @(negedge clk);
    check("ovr_set_wins", 64'(overrun_out), 64'd1);
    wait_done_count(1, FLEN + 20);
    repeat (5) tick_edge();
    check("ovr_set_wins_snaps", 64'(snap_n), 64'd1);
    overrun_clr_in = 1'b1;
    tick_edge();
    overrun_clr_in = 1'b0;
    $display("overrun sequences done overrun=%0b", overrun_out);

    // Asynchronous reset during channel 3 bit 5
    clear_stats();
    pulse_rtc();
    wait_sl(4);
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_frame", 64'(frame_out), 64'd1);
    check("pre_rst_addr", 64'(addr_out), 64'd3);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          64'({snap_out, addr_out, sl_out, serial_out, frame_out, busy_out, done_out, overrun_out}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick_edge();
    run_frame("after_rst", pat_a, 0);

    // Tick landing on the DONE cycle is an overrun
    clear_stats();
    pulse_rtc();
    begin int n = 0; while (snap_first < 0 && n < 10) begin tick_edge(); n++; end end
    s = snap_first;
    begin int n = 0; while (cyc < s + FLEN - 3 && n < FLEN) begin tick_edge(); n++; end end
    rtc_in = 1'b1;
    tick_edge();
    tick_edge();
    rtc_in = 1'b0;
    wait_done_count(1, FLEN + 20);
    repeat (20) tick_edge();
    check("b2b_done_ovr", 64'(overrun_out), 64'd1);
    check("b2b_done_snaps", 64'(snap_n), 64'd1);
    check("b2b_done_gap", 64'(done_last - s), 64'(FLEN - 1));
    $display("b2b done-cycle tick snap@%0d done@%0d overrun=%0b", s, done_last, overrun_out);
    overrun_clr_in = 1'b1;
    tick_edge();
    overrun_clr_in = 1'b0;

    // Tick landing on the first IDLE cycle starts a new frame
    clear_stats();
    pulse_rtc();
    begin int n = 0; while (snap_first < 0 && n < 10) begin tick_edge(); n++; end end
    s = snap_first;
    begin int n = 0; while (cyc < s + FLEN - 2 && n < FLEN) begin tick_edge(); n++; end end
    rtc_in = 1'b1;
    tick_edge();
    tick_edge();
    rtc_in = 1'b0;
    wait_done_count(2, 2 * FLEN + 20);
    repeat (5) tick_edge();
    check("b2b_idle_snaps", 64'(snap_n), 64'd2);
    check("b2b_idle_dones", 64'(done_n), 64'd2);
    check("b2b_idle_snap2", 64'(snap_last - done_first), 64'd2);
    check("b2b_idle_ovr", 64'(overrun_out), 64'd0);
    $display("b2b idle-cycle tick snap1@%0d done1@%0d snap2@%0d", s, done_first, snap_last);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
